// File: rtl/pwm_tick_if.sv
// pwm_tick_if: bundles the PWM generator's advance strobe, the
// double-buffered period/duty write port and the three status outputs.
// The master drives tick/top/duty/put; the slave (pwm_tick) drives the rest.
interface pwm_tick_if #(
   parameter int W = 8
);
   logic         tick;
   logic [W-1:0] top;
   logic [W-1:0] duty;
   logic         put;
   logic         out;
   logic         wrap;
   logic         pend;

   modport master (
      output tick, top, duty, put,
      input  out, wrap, pend
   );

   modport slave (
      input  tick, top, duty, put,
      output out, wrap, pend
   );
endinterface

// File: rtl/pwm_tick.sv
// pwm_tick: tick-driven PWM generator with double-buffered period/duty.
// The phase counter only moves on upstream strobe ticks; values written with
// put are parked in a pending buffer and loaded at the next period boundary,
// or loaded directly when the write lands on a boundary tick.
// Optional build macro: PWM_CENTER_EN selects center-aligned (up/down) mode.
module pwm_tick #(
   parameter int W = 8
) (
   input logic        clock,
   input logic        reset,
   pwm_tick_if.slave  bus
);

   logic [W-1:0] count_q, count_d;
   logic [W-1:0] top_a_q, top_a_d;
   logic [W-1:0] duty_a_q, duty_a_d;
   logic [W-1:0] top_p_q, top_p_d;
   logic [W-1:0] duty_p_q, duty_p_d;
   logic         pend_q, pend_d;
   logic         wrap_q, wrap_d;
   logic         out_q, out_d;
   logic         boundary;
`ifdef PWM_CENTER_EN
   logic         dir_q, dir_d;
`endif

   // Next-state: phase advance, boundary detection, buffer transfer, output compare.
   always_comb begin
      count_d  = count_q;
      top_a_d  = top_a_q;
      duty_a_d = duty_a_q;
      top_p_d  = top_p_q;
      duty_p_d = duty_p_q;
      pend_d   = pend_q;
      wrap_d   = 1'b0;
      boundary = 1'b0;
`ifdef PWM_CENTER_EN
      dir_d    = dir_q;
      if (bus.tick) begin
         if (dir_q) begin
            // Falling half: the step from 1 back to 0 closes the period.
            if (count_q <= W'(1)) begin
               boundary = 1'b1;
            end else begin
               count_d = count_q - W'(1);
            end
         end else if (top_a_q == '0) begin
            // Degenerate period: no room to turn around, every tick wraps.
            boundary = 1'b1;
         end else if (count_q >= top_a_q) begin
            // Turn around at the top; clamp in case a smaller top was just loaded.
            dir_d   = 1'b1;
            count_d = top_a_q - W'(1);
         end else begin
            count_d = count_q + W'(1);
         end
      end
`else
      // >= rather than == so a count stranded above a freshly shrunk top
      // still wraps on its next tick.
      if (bus.tick) begin
         if (count_q >= top_a_q) begin
            boundary = 1'b1;
         end else begin
            count_d = count_q + W'(1);
         end
      end
`endif
      if (boundary) begin
         count_d = '0;
         wrap_d  = 1'b1;
`ifdef PWM_CENTER_EN
         dir_d   = 1'b0;
`endif
         if (bus.put) begin
            // Write coinciding with the boundary bypasses the pending buffer.
            top_a_d  = bus.top;
            duty_a_d = bus.duty;
            pend_d   = 1'b0;
         end else if (pend_q) begin
            top_a_d  = top_p_q;
            duty_a_d = duty_p_q;
            pend_d   = 1'b0;
         end
      end else if (bus.put) begin
         top_p_d  = bus.top;
         duty_p_d = bus.duty;
         pend_d   = 1'b1;
      end
      // Compare against post-edge values so out moves on the same edge as count.
      out_d = (count_d < duty_a_d);
   end

   // State register with synchronous reset that also discards pending values.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q  <= '0;
         top_a_q  <= '0;
         duty_a_q <= '0;
         top_p_q  <= '0;
         duty_p_q <= '0;
         pend_q   <= 1'b0;
         wrap_q   <= 1'b0;
         out_q    <= 1'b0;
`ifdef PWM_CENTER_EN
         dir_q    <= 1'b0;
`endif
      end else begin
         count_q  <= count_d;
         top_a_q  <= top_a_d;
         duty_a_q <= duty_a_d;
         top_p_q  <= top_p_d;
         duty_p_q <= duty_p_d;
         pend_q   <= pend_d;
         wrap_q   <= wrap_d;
         out_q    <= out_d;
`ifdef PWM_CENTER_EN
         dir_q    <= dir_d;
`endif
      end
   end

   assign bus.out  = out_q;
   assign bus.wrap = wrap_q;
   assign bus.pend = pend_q;

endmodule

// File: tb/tb_pwm_tick.sv
// tb_pwm_tick: scoreboard bench for pwm_tick. Each cycle the expected
// {out, wrap, pend} from a behavioural model is queued when inputs are
// driven and popped when the DUT outputs are sampled; directed pattern
// checks from the test plan are layered on top.
module tb_pwm_tick;

   logic clock;
   logic reset;

   pwm_tick_if #(.W(8)) bus ();

   pwm_tick #(.W(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;

   logic [2:0] sb_q[$];
   logic       last_out, last_wrap, last_pend;
   string      phase = "init";

   // Behavioural model state
   logic [7:0] m_count, m_top_a, m_duty_a, m_top_p, m_duty_p;
   logic       m_pend, m_dir;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic rst, input logic tk, input logic pt,
                             input logic [7:0] tp, input logic [7:0] dt,
                             output logic [2:0] e);
      logic bnd;
      if (rst) begin
         m_count = 0; m_top_a = 0; m_duty_a = 0; m_top_p = 0; m_duty_p = 0;
         m_pend = 0; m_dir = 0;
         e = 3'b000;
      end else begin
         bnd = 1'b0;
         if (tk) begin
`ifdef PWM_CENTER_EN
            if (m_dir) begin
               if (m_count == 8'd1) bnd = 1'b1;
               else m_count = m_count - 8'd1;
            end else if (m_top_a == 8'd0) begin
               bnd = 1'b1;
            end else if (m_count == m_top_a) begin
               m_dir   = 1'b1;
               m_count = m_count - 8'd1;
            end else begin
               m_count = m_count + 8'd1;
            end
`else
            if (m_count >= m_top_a) bnd = 1'b1;
            else m_count = m_count + 8'd1;
`endif
         end
         if (bnd) begin
            m_count = 0;
            m_dir   = 0;
            if (pt) begin
               m_top_a = tp; m_duty_a = dt; m_pend = 0;
            end else if (m_pend) begin
               m_top_a = m_top_p; m_duty_a = m_duty_p; m_pend = 0;
            end
         end else if (pt) begin
            m_top_p = tp; m_duty_p = dt; m_pend = 1;
         end
         e = {(m_count < m_duty_a), bnd, m_pend};
      end
   endtask

   // One clock: drive inputs on the falling edge, score outputs after the rising edge.
   task automatic step(input logic rst, input logic tk, input logic pt,
                       input logic [7:0] tp, input logic [7:0] dt);
      logic [2:0] e;
      @(negedge clock);
      reset    = rst;
      bus.tick = tk;
      bus.put  = pt;
      bus.top  = tp;
      bus.duty = dt;
      model_step(rst, tk, pt, tp, dt, e);
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      last_out  = bus.out;
      last_wrap = bus.wrap;
      last_pend = bus.pend;
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check_eq("out",  {31'd0, last_out},  {31'd0, e[2]});
         check_eq("wrap", {31'd0, last_wrap}, {31'd0, e[1]});
         check_eq("pend", {31'd0, last_pend}, {31'd0, e[0]});
      end
      $display("[%0t] %s rst=%0d tick=%0d put=%0d top=%0d duty=%0d -> out=%0d wrap=%0d pend=%0d",
               $time, phase, rst, tk, pt, tp, dt, last_out, last_wrap, last_pend);
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
   endtask

   initial begin
      logic pat4 [0:3];
      logic pat8 [0:7];
      int   highs, wraps;
      bit   found;

      reset = 1'b1; bus.tick = 1'b0; bus.put = 1'b0; bus.top = '0; bus.duty = '0;

      // Reset state
      phase = "reset";
      step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      step(1'b1, 1'b1, 1'b1, 8'd5, 8'd5);
      check_eq("rst_out",  {31'd0, last_out},  32'd0);
      check_eq("rst_wrap", {31'd0, last_wrap}, 32'd0);
      check_eq("rst_pend", {31'd0, last_pend}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

`ifndef PWM_CENTER_EN
      // 1: put top=3 duty=2 on an idle tick, tick every clock
      phase = "t1";
      pat4 = '{1'b1, 1'b1, 1'b0, 1'b0};
      step(1'b0, 1'b1, 1'b1, 8'd3, 8'd2);
      check_eq("t1_pend", {31'd0, last_pend}, 32'd0);
      for (int i = 0; i < 12; i++) begin
         if (i > 0) tick_n(1);
         check_eq("t1_out",  {31'd0, last_out},  {31'd0, pat4[i % 4]});
         check_eq("t1_wrap", {31'd0, last_wrap}, (i % 4 == 0) ? 32'd1 : 32'd0);
      end

      // 2: tick every 3rd clock
      phase = "t2";
      highs = 0; wraps = 0;
      for (int i = 0; i < 24; i++) begin
         step(1'b0, (i % 3 == 0), 1'b0, 8'd0, 8'd0);
         highs += int'(last_out);
         wraps += int'(last_wrap);
      end
      check_eq("t2_highs", highs, 32'd12);
      check_eq("t2_wraps", wraps, 32'd2);

      // 3: buffered update mid-period
      phase = "t3";
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (m_count == 8'd1) found = 1'b1;
         else tick_n(1);
      end
      check_eq("t3_sync", {31'd0, found}, 32'd1);
      step(1'b0, 1'b1, 1'b1, 8'd7, 8'd1);
      check_eq("t3_pend_a", {31'd0, last_pend}, 32'd1);
      check_eq("t3_out_a",  {31'd0, last_out},  32'd0);
      tick_n(1);
      check_eq("t3_pend_b", {31'd0, last_pend}, 32'd1);
      check_eq("t3_out_b",  {31'd0, last_out},  32'd0);
      for (int i = 0; i < 9; i++) begin
         tick_n(1);
         check_eq("t3_out",  {31'd0, last_out},  (i % 8 == 0) ? 32'd1 : 32'd0);
         check_eq("t3_wrap", {31'd0, last_wrap}, (i % 8 == 0) ? 32'd1 : 32'd0);
         check_eq("t3_pend", {31'd0, last_pend}, 32'd0);
      end

      // 4: duty extremes
      for (int k = 0; k < 2; k++) begin
         phase = (k == 0) ? "t4_duty0" : "t4_duty9";
         step(1'b0, 1'b0, 1'b1, 8'd7, (k == 0) ? 8'd0 : 8'd9);
         check_eq("t4_pend", {31'd0, last_pend}, 32'd1);
         found = 1'b0;
         for (int i = 0; i < 10 && !found; i++) begin
            tick_n(1);
            found = last_wrap;
         end
         check_eq("t4_sync", {31'd0, found}, 32'd1);
         highs = 0; wraps = 0;
         for (int i = 0; i < 16; i++) begin
            tick_n(1);
            highs += int'(last_out);
            wraps += int'(last_wrap);
         end
         check_eq("t4_highs", highs, (k == 0) ? 32'd0 : 32'd16);
         check_eq("t4_wraps", wraps, 32'd2);
      end

      // 5: reset mid-period with a pending write
      phase = "t5";
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (m_count == 8'd2) found = 1'b1;
         else tick_n(1);
      end
      check_eq("t5_sync", {31'd0, found}, 32'd1);
      step(1'b0, 1'b0, 1'b1, 8'd5, 8'd3);
      check_eq("t5_pend_set", {31'd0, last_pend}, 32'd1);
      step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
      check_eq("t5_out",  {31'd0, last_out},  32'd0);
      check_eq("t5_wrap", {31'd0, last_wrap}, 32'd0);
      check_eq("t5_pend", {31'd0, last_pend}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick_n(1);
         check_eq("t5_idle_out", {31'd0, last_out}, 32'd0);
      end
`else
      // 6: center-aligned, top=4 duty=2
      phase = "t6";
      pat8 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      step(1'b0, 1'b1, 1'b1, 8'd4, 8'd2);
      wraps = 0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) tick_n(1);
         wraps += int'(last_wrap);
         check_eq("t6_out",  {31'd0, last_out},  {31'd0, pat8[i % 8]});
         check_eq("t6_wrap", {31'd0, last_wrap}, (i % 8 == 0) ? 32'd1 : 32'd0);
      end
      check_eq("t6_wraps", wraps, 32'd2);
      // Buffered change in center mode
      phase = "t6_buf";
      step(1'b0, 1'b0, 1'b1, 8'd2, 8'd1);
      check_eq("t6_pend", {31'd0, last_pend}, 32'd1);
      tick_n(12);
      check_eq("t6_pend_clr", {31'd0, last_pend}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
